// File: rtl/rtc_pkg.sv
// Shared widths, limits and types for the calendar-timer alarm scheduler.
package rtc_pkg;

    localparam int HRS_W = 5;
    localparam int MIN_W = 6;
    localparam int SEC_W = 6;

    localparam logic [HRS_W-1:0] HRS_MAX = 5'd23;
    localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;
    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;

    typedef struct packed {
        logic             en;
        logic [HRS_W-1:0] hrs;
        logic [MIN_W-1:0] min;
        logic [SEC_W-1:0] sec;
    } alarm_t;

    typedef struct packed {
        logic [HRS_W-1:0] hrs;
        logic [MIN_W-1:0] min;
        logic [SEC_W-1:0] sec;
    } tod_t;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } sched_state_t;

    // Slots holding out-of-range values are kept as written but must never fire.
    function automatic logic tod_in_range(input logic [HRS_W-1:0] hrs,
                                          input logic [MIN_W-1:0] min,
                                          input logic [SEC_W-1:0] sec);
        return (hrs <= HRS_MAX) && (min <= MIN_MAX) && (sec <= SEC_MAX);
    endfunction

endpackage

// File: rtl/rtc_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after i_ptr, wrapping.
module rtc_rr_arbiter #(
    parameter  int N   = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic [N-1:0]   i_req,
    input  logic [IDW-1:0] i_ptr,
    output logic [IDW-1:0] o_grant,
    output logic           o_any
);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        o_grant = '0;
        o_any   = 1'b0;
        // Walk from the farthest candidate back toward i_ptr so the nearest request wins.
        for (int k = N - 1; k >= 0; k--) begin
            if (i_req[(int'(i_ptr) + k) % N]) begin
                o_grant = IDW'((int'(i_ptr) + k) % N);
                o_any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rtc_alarm_scheduler.sv
// Alarm scheduler: scans NUM_ALARMS time-of-day slots once per time sample and
// dispatches latched matches round-robin on a valid/ready event port.
module rtc_alarm_scheduler
    import rtc_pkg::*;
#(
    parameter  int NUM_ALARMS = 4,
    localparam int IDW        = $clog2(NUM_ALARMS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_cfg_valid,
    output logic                  o_cfg_ready,
    input  logic [IDW-1:0]        i_cfg_id,
    input  logic                  i_cfg_en,
    input  logic [HRS_W-1:0]      i_cfg_hrs,
    input  logic [MIN_W-1:0]      i_cfg_min,
    input  logic [SEC_W-1:0]      i_cfg_sec,
    input  logic                  i_time_valid,
    input  logic [HRS_W-1:0]      i_cur_hrs,
    input  logic [MIN_W-1:0]      i_cur_min,
    input  logic [SEC_W-1:0]      i_cur_sec,
    output logic                  o_evt_valid,
    output logic [IDW-1:0]        o_evt_id,
    input  logic                  i_evt_ready,
    output logic [NUM_ALARMS-1:0] o_pending,
    output logic                  o_miss,
    output logic                  o_scan_ovr
);

    localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_ALARMS - 1);

    sched_state_t          r_state, w_state_nxt;
    alarm_t                r_slots [NUM_ALARMS];
    tod_t                  r_snap;
    logic [IDW-1:0]        r_idx, r_evt_id, r_rr_ptr;
    logic [NUM_ALARMS-1:0] r_pending;
    logic                  r_evt_valid, r_miss, r_scan_ovr;

    logic                  w_scan_start, w_cfg_wr, w_hs, w_match, w_miss, w_any;
    logic [IDW-1:0]        w_grant;
    logic [NUM_ALARMS-1:0] w_set, w_clr, w_cfg_clr;
    alarm_t                w_slot;

    always_comb begin
        w_state_nxt  = r_state;
        o_cfg_ready  = 1'b0;
        w_scan_start = 1'b0;
        case (r_state)
            IDLE: begin
                o_cfg_ready  = 1'b1;
                w_scan_start = i_time_valid;
                if (i_time_valid) w_state_nxt = SCAN;
            end
            SCAN:    if (r_idx == LAST_ID) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_slot    = r_slots[r_idx];
        w_match   = (r_state == SCAN) && w_slot.en
                  && tod_in_range(w_slot.hrs, w_slot.min, w_slot.sec)
                  && ({w_slot.hrs, w_slot.min, w_slot.sec} == r_snap);
        w_hs      = r_evt_valid && i_evt_ready;
        w_cfg_wr  = i_cfg_valid && o_cfg_ready;
        w_cfg_clr = '0;
        w_set     = '0;
        // Disabling the slot currently on the event port must not cancel that event.
        if (w_cfg_wr && !i_cfg_en && !(r_evt_valid && r_evt_id == i_cfg_id))
            w_cfg_clr[i_cfg_id] = 1'b1;
        w_clr = w_cfg_clr;
        if (w_hs)    w_clr[r_evt_id] = 1'b1;
        if (w_match) w_set[r_idx]    = 1'b1;
        w_miss = w_match && r_pending[r_idx] && !w_clr[r_idx];
    end

    rtc_rr_arbiter #(.N(NUM_ALARMS)) u_arb (
        .i_req   (r_pending & ~w_cfg_clr),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_any   (w_any)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // NOTE: the slot table is reset rather than left uninitialised so a stale
    // enable can never fire after rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ALARMS; i++) r_slots[i] <= '0;
            r_snap      <= '0;
            r_idx       <= '0;
            r_pending   <= '0;
            r_evt_valid <= 1'b0;
            r_evt_id    <= '0;
            r_rr_ptr    <= '0;
            r_miss      <= 1'b0;
            r_scan_ovr  <= 1'b0;
        end else begin
            if (w_cfg_wr)
                r_slots[i_cfg_id] <= '{en: i_cfg_en, hrs: i_cfg_hrs, min: i_cfg_min, sec: i_cfg_sec};
            if (w_scan_start) begin
                r_snap <= '{hrs: i_cur_hrs, min: i_cur_min, sec: i_cur_sec};
                r_idx  <= '0;
            end else if (r_state == SCAN && r_idx != LAST_ID) begin
                r_idx <= r_idx + 1'b1;
            end
            r_pending  <= (r_pending & ~w_clr) | w_set;
            r_miss     <= w_miss;
            r_scan_ovr <= (r_state == SCAN) && i_time_valid;
            if (!r_evt_valid && w_any) begin
                r_evt_valid <= 1'b1;
                r_evt_id    <= w_grant;
            end else if (w_hs) begin
                r_evt_valid <= 1'b0;
                r_rr_ptr    <= (r_evt_id == LAST_ID) ? '0 : r_evt_id + 1'b1;
            end
        end
    end

    assign o_evt_valid = r_evt_valid;
    assign o_evt_id    = r_evt_id;
    assign o_pending   = r_pending;
    assign o_miss      = r_miss;
    assign o_scan_ovr  = r_scan_ovr;

endmodule

// File: tb/tb_rtc_alarm_scheduler.sv
// Directed scenarios plus randomized traffic, checked every cycle against a
// cycle-count based behavioural model of the alarm scheduler.
module tb_rtc_alarm_scheduler;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid = 1'b0, cfg_en = 1'b0, time_valid = 1'b0, evt_ready = 1'b0;
    logic [1:0] cfg_id = '0;
    logic [4:0] cfg_hrs = '0, cur_hrs = '0;
    logic [5:0] cfg_min = '0, cfg_sec = '0, cur_min = '0, cur_sec = '0;
    logic       o_cfg_ready, o_evt_valid, o_miss, o_scan_ovr;
    logic [1:0] o_evt_id;
    logic [3:0] o_pending;

    rtc_alarm_scheduler #(.NUM_ALARMS(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_cfg_valid  (cfg_valid),
        .o_cfg_ready  (o_cfg_ready),
        .i_cfg_id     (cfg_id),
        .i_cfg_en     (cfg_en),
        .i_cfg_hrs    (cfg_hrs),
        .i_cfg_min    (cfg_min),
        .i_cfg_sec    (cfg_sec),
        .i_time_valid (time_valid),
        .i_cur_hrs    (cur_hrs),
        .i_cur_min    (cur_min),
        .i_cur_sec    (cur_sec),
        .o_evt_valid  (o_evt_valid),
        .o_evt_id     (o_evt_id),
        .i_evt_ready  (evt_ready),
        .o_pending    (o_pending),
        .o_miss       (o_miss),
        .o_scan_ovr   (o_scan_ovr)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    int cyc = 0, miss_cnt = 0;
    int evt_log[$];

    // Behavioural model: a scan is "the N cycles after an accepted strobe".
    int       m_en[N], m_h[N], m_m[N], m_s[N];
    int       m_start, m_sh, m_sm, m_ss;
    logic [N-1:0] m_pend;
    bit       m_evt_valid, m_miss, m_ovr;
    int       m_evt_id, m_ptr;

    int tt_h[6] = '{7, 12, 23, 0, 24, 23};
    int tt_m[6] = '{30, 0, 59, 0, 0, 60};
    int tt_s[6] = '{0, 59, 59, 0, 0, 0};

    task automatic check(string name, int act, int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit busy_at(int c);
        return (c - m_start >= 1) && (c - m_start <= N);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_en[i] = 0; m_h[i] = 0; m_m[i] = 0; m_s[i] = 0;
        end
        m_start = -1000; m_sh = 0; m_sm = 0; m_ss = 0;
        m_pend = '0; m_evt_valid = 0; m_evt_id = 0; m_ptr = 0;
        m_miss = 0; m_ovr = 0;
    endtask

    task automatic model_update();
        int si;
        int ci;
        bit busy, hs, hit;
        logic [N-1:0] clr, set, req;
        si   = cyc - m_start - 1;
        ci   = int'(cfg_id);
        busy = busy_at(cyc);
        hs   = m_evt_valid && evt_ready;
        hit  = 0;
        clr  = '0;
        set  = '0;
        if (busy)
            hit = (m_en[si] != 0) && m_h[si] == m_sh && m_m[si] == m_sm && m_s[si] == m_ss
               && m_h[si] <= 23 && m_m[si] <= 59 && m_s[si] <= 59;
        if (cfg_valid && !busy && !cfg_en && !(m_evt_valid && m_evt_id == ci)) clr[ci] = 1'b1;
        req = m_pend & ~clr;
        if (hs) clr[m_evt_id] = 1'b1;
        if (hit) set[si] = 1'b1;
        m_miss = hit && m_pend[si] && !clr[si];
        m_ovr  = time_valid && busy;
        if (!m_evt_valid) begin
            for (int k = 0; k < N; k++) begin
                if (!m_evt_valid && req[(m_ptr + k) % N]) begin
                    m_evt_valid = 1;
                    m_evt_id    = (m_ptr + k) % N;
                end
            end
        end else if (hs) begin
            m_evt_valid = 0;
            m_ptr       = (m_evt_id + 1) % N;
        end
        m_pend = (m_pend & ~clr) | set;
        if (cfg_valid && !busy) begin
            m_en[ci] = int'(cfg_en); m_h[ci] = int'(cfg_hrs);
            m_m[ci]  = int'(cfg_min); m_s[ci] = int'(cfg_sec);
        end
        if (time_valid && !busy) begin
            m_start = cyc; m_sh = int'(cur_hrs); m_sm = int'(cur_min); m_ss = int'(cur_sec);
        end
    endtask

    task automatic check_all();
        check("cfg_ready", int'(o_cfg_ready), int'(!busy_at(cyc)));
        check("evt_valid", int'(o_evt_valid), int'(m_evt_valid));
        if (m_evt_valid) check("evt_id", int'(o_evt_id), m_evt_id);
        check("pending", int'(o_pending), int'(m_pend));
        check("miss", int'(o_miss), int'(m_miss));
        check("scan_ovr", int'(o_scan_ovr), int'(m_ovr));
    endtask

    task automatic tick();
        if (o_evt_valid && evt_ready) evt_log.push_back(int'(o_evt_id));
        model_update();
        @(negedge clk);
        cyc++;
        if (o_miss) miss_cnt++;
        check_all();
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic cfg_write(int id, int en, int h, int m, int s);
        cfg_valid = 1'b1; cfg_id = 2'(id); cfg_en = 1'(en);
        cfg_hrs = 5'(h); cfg_min = 6'(m); cfg_sec = 6'(s);
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic strobe(int h, int m, int s);
        time_valid = 1'b1; cur_hrs = 5'(h); cur_min = 6'(m); cur_sec = 6'(s);
        tick();
        time_valid = 1'b0;
    endtask

    task automatic check_log(string name, int n, int e0, int e1, int e2, int e3);
        int exp[4];
        exp = '{e0, e1, e2, e3};
        check({name, "_count"}, evt_log.size(), n);
        for (int i = 0; i < n; i++)
            check({name, "_order"}, (evt_log.size() > i) ? evt_log[i] : -1, exp[i]);
    endtask

    initial begin
        do_reset();
        check("rst_cfg_ready", int'(o_cfg_ready), 1);
        check("rst_pending", int'(o_pending), 0);

        // 1: single alarm, delayed acknowledge
        cfg_write(0, 1, 7, 30, 0);
        strobe(7, 30, 0);
        tick();
        check("t1_pend_T2", int'(o_pending), 4'b0001);
        tick();
        check("t1_valid_T3", int'(o_evt_valid), 1);
        check("t1_id_T3", int'(o_evt_id), 0);
        tick();
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        check("t1_pend_clr", int'(o_pending), 0);

        // 2: three slots on one time, ready tied high; then a blocked port reorders
        cfg_write(0, 1, 12, 0, 59);
        cfg_write(1, 1, 12, 0, 59);
        cfg_write(3, 1, 12, 0, 59);
        cfg_write(2, 1, 6, 15, 30);
        evt_log.delete();
        evt_ready = 1'b1;
        strobe(12, 0, 59);
        run(8);
        evt_ready = 1'b0;
        check_log("t2a", 3, 0, 1, 3, 0);
        strobe(6, 15, 30);
        run(N + 1);
        strobe(12, 0, 59);
        run(N + 1);
        check("t2b_pend_all", int'(o_pending), 4'b1111);
        evt_log.delete();
        evt_ready = 1'b1;
        run(8);
        evt_ready = 1'b0;
        check_log("t2b", 4, 2, 3, 0, 1);

        // 3: re-match of an unacknowledged slot
        strobe(6, 15, 30);
        run(N + 1);
        miss_cnt = 0;
        strobe(6, 15, 30);
        run(N + 2);
        check("t3_miss_once", miss_cnt, 1);
        check("t3_pend", int'(o_pending), 4'b0100);
        evt_log.delete();
        evt_ready = 1'b1;
        run(4);
        evt_ready = 1'b0;
        check_log("t3", 1, 2, 0, 0, 0);

        // 4: strobe inside a scan, config held off until idle
        time_valid = 1'b1; cur_hrs = 5'd1; cur_min = 6'd2; cur_sec = 6'd3;
        tick();
        time_valid = 1'b0;
        cfg_valid = 1'b1; cfg_id = 2'd2; cfg_en = 1'b1;
        cfg_hrs = 5'd6; cfg_min = 6'd15; cfg_sec = 6'd30;
        tick();
        time_valid = 1'b1;
        tick();
        time_valid = 1'b0;
        check("t4_scan_ovr", int'(o_scan_ovr), 1);
        check("t4_cfg_blocked", int'(o_cfg_ready), 0);
        run(2);
        check("t4_cfg_ready", int'(o_cfg_ready), 1);
        tick();
        cfg_valid = 1'b0;

        // 5: disable a waiting slot, then disable the offered one
        cfg_write(0, 1, 18, 45, 10);
        cfg_write(1, 1, 18, 45, 10);
        strobe(18, 45, 10);
        run(N + 1);
        check("t5_pend_both", int'(o_pending), 4'b0011);
        cfg_write(1, 0, 18, 45, 10);
        check("t5_pend_dis", int'(o_pending), 4'b0001);
        cfg_write(0, 0, 18, 45, 10);
        check("t5_offer_kept", int'(o_evt_valid), 1);
        evt_log.delete();
        evt_ready = 1'b1;
        run(4);
        evt_ready = 1'b0;
        check_log("t5", 1, 0, 0, 0, 0);

        // 6: reset during a scan with an event offered
        cfg_write(0, 1, 18, 45, 10);
        strobe(18, 45, 10);
        run(2);
        check("t6_pre_valid", int'(o_evt_valid), 1);
        do_reset();
        check("t6_rst_valid", int'(o_evt_valid), 0);
        check("t6_rst_ready", int'(o_cfg_ready), 1);
        strobe(18, 45, 10);
        run(N + 3);
        check("t6_no_stale", int'(o_pending), 0);

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            int t;
            if ($urandom_range(0, 499) == 0) begin
                cfg_valid = 1'b0; time_valid = 1'b0; evt_ready = 1'b0;
                do_reset();
            end
            t = $urandom_range(0, 5);
            cfg_valid = ($urandom_range(0, 7) == 0);
            cfg_id    = 2'($urandom_range(0, N - 1));
            cfg_en    = ($urandom_range(0, 3) != 0);
            cfg_hrs   = 5'(tt_h[t]); cfg_min = 6'(tt_m[t]); cfg_sec = 6'(tt_s[t]);
            t = $urandom_range(0, 5);
            time_valid = ($urandom_range(0, 5) == 0);
            cur_hrs    = 5'(tt_h[t]); cur_min = 6'(tt_m[t]); cur_sec = 6'(tt_s[t]);
            evt_ready  = ($urandom_range(0, 1) == 1);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
